// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step, fetch state enum and prefetch queue entry type
package fetch_pkg;
    localparam int INSTR_W = 16;
    localparam int ADDR_W = 16;
    localparam logic [ADDR_W-1:0] PC_STEP = 16'h0002;
    typedef enum logic {RUN, FAULT} fetch_state_e;
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous prefetch FIFO of {pc, instr} entries; flush beats push
module fetch_queue import fetch_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t din_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    // pointer and occupancy next state; a flush empties the queue regardless of push/pop
    always_comb begin
        rd_d  = flush_i ? '0 : rd_q + AW'(pop_ok);
        wr_d  = flush_i ? '0 : wr_q + AW'(push_ok);
        cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
    // pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
    // entry storage; contents are don't-care while empty since the head is gated
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with prefetch queue and redirect; FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap
module fetch_unit import fetch_pkg::*; #(
    parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
    parameter int                QUEUE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  PC,
    input  logic [INSTR_W-1:0] instruction,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               fault
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, target;
    logic              push, pop, full, empty;
    fetch_entry_t      din, head;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign target = redirect_pc;
    assign fault  = state_q == FAULT;
`else
    assign target = redirect_pc & ~16'h0001;
    assign fault  = 1'b0;
`endif
    assign PC        = pc_q;
    assign pop       = out_valid & out_ready;
    assign out_valid = ~empty;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign din       = '{pc: pc_q, instr: instruction};
    // redirect wins over fetch; otherwise fetch whenever the queue has or is making room
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        if (redirect) begin
            pc_d = target;
`ifdef FETCH_MISALIGN_TRAP_EN
            state_d = target[0] ? FAULT : RUN;
`endif
        end else if (state_q == RUN && (!full || pop)) begin
            push = 1'b1;
            pc_d = pc_q + PC_STEP;
        end
    end
    // fetch state and program counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end
    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .din_i   (din),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against an instruction-stream model
module tb_fetch_unit;
    import fetch_pkg::*;
    localparam logic [15:0] RST_PC = 16'h0100;
    logic        clk = 1'b0, rst = 1'b1, out_ready = 1'b0, redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        out_valid, fault;
    logic [15:0] PC, instruction, out_instr, out_pc, pc1;
    logic [7:0]  mem [65536];
    fetch_entry_t exp_q [$];
    fetch_entry_t e;
    int          n_cmp = 0, n_bad = 0;
    logic        fault_m = 1'b0, prev_rst = 1'b0, prev_redir = 1'b0, started = 1'b0, exp_v;

    assign pc1 = PC + 16'd1;
    assign instruction = {mem[pc1], mem[PC]};
    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .PC(PC), .instruction(instruction),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .redirect(redirect), .redirect_pc(redirect_pc), .fault(fault)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // expected accepted stream after a restart: consecutive halfwords from base, 16-bit wrap
    task automatic refill(input logic [15:0] base);
        fetch_entry_t en;
        logic [15:0] p, q;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            p = base + 16'(2 * i);
            q = p + 16'd1;
            en.pc = p;
            en.instr = {mem[q], mem[p]};
            exp_q.push_back(en);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rd, input logic [15:0] rpc);
        rst = r; out_ready = rdy; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        if (r) begin
            fault_m = 1'b0;
            refill(RST_PC);
        end else if (rd) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_m = rpc[0];
            if (rpc[0]) exp_q.delete();
            else refill(rpc);
`else
            refill(rpc & 16'hFFFE);
`endif
        end
        #1;
    endtask

    // monitor: checks presence, fault and every accepted head against the model stream
    always @(negedge clk) begin
        if (started) begin
            exp_v = !(prev_rst || prev_redir || fault_m);
            chk("out_valid", {15'd0, out_valid}, {15'd0, exp_v});
            chk("fault", {15'd0, fault}, {15'd0, fault_m});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL pop_empty: got pc %h expected no entry", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_instr", out_instr, e.instr);
                end
            end
        end
        prev_rst = rst;
        prev_redir = redirect;
        if (rst) started = 1'b1;
    end

    initial begin
        logic r, rd;
        logic [15:0] rpc;
        int since;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        // reset state
        drive(1, 0, 0, 16'h0);
        drive(1, 1, 0, 16'h0);
        chk("rst_pc", PC, RST_PC);
        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_pc", out_pc, 16'd0);
        chk("rst_out_instr", out_instr, 16'd0);
        chk("rst_fault", {15'd0, fault}, 16'd0);
        repeat (6) drive(0, 1, 0, 16'h0);
        chk("run_pc", PC, RST_PC + 16'd12);
        chk("run_head", out_pc, RST_PC + 16'd10);
        // stall: two entries then PC frozen
        drive(0, 0, 1, 16'h1000);
        repeat (5) drive(0, 0, 0, 16'h0);
        chk("stall_pc", PC, 16'h1004);
        chk("stall_head", out_pc, 16'h1000);
        repeat (4) drive(0, 1, 0, 16'h0);
        // redirect while full with a same-cycle pop
        drive(0, 0, 1, 16'h1800);
        repeat (3) drive(0, 0, 0, 16'h0);
        drive(0, 1, 1, 16'h2000);
        chk("redir_pc", PC, 16'h2000);
        chk("redir_valid", {15'd0, out_valid}, 16'd0);
        drive(0, 1, 0, 16'h0);
        chk("redir_head", out_pc, 16'h2000);
        // wrap at the top of the address space
        drive(0, 1, 1, 16'hFFFC);
        repeat (3) drive(0, 1, 0, 16'h0);
        chk("wrap_head", out_pc, 16'h0000);
        repeat (2) drive(0, 1, 0, 16'h0);
        // misaligned redirect
        drive(0, 1, 1, 16'h3001);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("odd_pc", PC, 16'h3001);
        chk("odd_fault", {15'd0, fault}, 16'd1);
        repeat (3) drive(0, 1, 0, 16'h0);
        chk("odd_hold_pc", PC, 16'h3001);
        drive(0, 1, 1, 16'h3000);
        chk("clr_fault", {15'd0, fault}, 16'd0);
        chk("clr_pc", PC, 16'h3000);
`else
        chk("odd_pc", PC, 16'h3000);
`endif
        repeat (3) drive(0, 1, 0, 16'h0);
        // reset overrides a simultaneous redirect
        drive(1, 1, 1, 16'h4000);
        chk("rst_redir_pc", PC, RST_PC);
        chk("rst_redir_valid", {15'd0, out_valid}, 16'd0);
        drive(0, 1, 0, 16'h0);
        // randomized traffic
        since = 0;
        repeat (1500) begin
            r = ($urandom % 64) == 0;
            rd = (($urandom % 16) == 0) || since >= 100;
            rpc = 16'($urandom);
            since = (r || rd) ? 0 : since + 1;
            drive(r, ($urandom % 4) != 0, rd, rpc);
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
